tc_moore_nway: RTL and testbench
================================

# tc_moore_nway

Parametrised Moore traffic-light controller for an N-way junction. It is the successor of the two-road TC_Moore. It adds a configurable number of approaches, minimum-green and yellow durations, a mandatory all-red clearance phase, round-robin service of waiting approaches, and an emergency all-red hold. It sits between the road sensor inputs and the lamp drivers. It is clocked by the system clock.

## Interface
- N_WAY, 4, number of approaches (2..8).
- GREEN_MIN, 4, minimum green duration in cycles (>=1).
- YELLOW_T, 5, yellow duration in cycles (>=1).
- CLK  input  1  system clock, rising edge.
- R  input  1  reset; synchronous, active-low (sampled on rising CLK, asserted when 0).
- T  input  N_WAY  traffic sensor per approach, 1 = vehicle waiting.
- EMG  input  1  emergency request, 1 = drive junction to all-red and hold.
- L  output  3*N_WAY  lamps; L[3i+2:3i] = approach i, encoding {red,yellow,green}: 3'b100 red, 3'b010 yellow, 3'b001 green.
- ACTIVE  output  $clog2(N_WAY)  index of the approach currently holding right of way.
- PHASE  output  2  current state code (GREEN=0, YELLOW=1, ALLRED=2, HOLD=3).

## Operation
- State registers: state, active index, cycle counter cnt (0 on the first cycle of each state, saturating).
- Outputs are decoded purely from the registers (Moore). In GREEN/YELLOW, approach `active` shows green/yellow and all others show red. ALLRED/HOLD: every approach red.
- GREEN: leave for YELLOW when (EMG=1) or (cnt>=GREEN_MIN-1 and T[active]=0 and any other T bit =1). EMG=1 overrides GREEN_MIN. Otherwise stay green indefinitely.
- YELLOW: lasts exactly YELLOW_T cycles. EMG does not shorten it. Then go to ALLRED.
- ALLRED: lasts exactly 1 cycle. At exit: if EMG=1, go to HOLD. Else set active = next approach and go to GREEN.
- HOLD: all red while EMG=1. When EMG=0 is sampled, go to ALLRED (one clearance cycle), then grant.
- Next approach: the first index j = active+1, active+2, ... (mod N_WAY), j != active, with T[j]=1. If none is waiting, use (active+1) mod N_WAY.
- Reset (R=0 at a rising edge): state=GREEN, active=0, cnt=0. This overrides all other activity, including mid-yellow and HOLD.

## Timing
- Reset values: L = approach 0 3'b001, all others 3'b100. ACTIVE=0, PHASE=0.
- Inputs are sampled on rising CLK. A state change is visible on L in the cycle after the sampling edge. There is no combinational input-to-output path.
- Green lasts at least GREEN_MIN cycles unless EMG is asserted. Yellow lasts exactly YELLOW_T cycles. Clearance is exactly 1 cycle.
- Minimum handover latency, from the sampled T condition to the next approach's green: YELLOW_T+1 cycles after the GREEN exit edge.
- Simultaneous requests: round-robin order from active+1. The active approach is never re-granted directly while another is waiting.
- If EMG pulses for 1 cycle during GREEN, the full YELLOW→ALLRED sequence still completes. EMG is then 0 at ALLRED exit, so the next approach is granted with no HOLD.
- cnt width is $clog2(max(GREEN_MIN,YELLOW_T)+1). cnt saturates and never wraps.

## Structure
- Package tc_pkg: lamp encoding constants (LAMP_RED, LAMP_YEL, LAMP_GRN) and the state enum (GREEN, YELLOW, ALLRED, HOLD) with the PHASE codes above.
- Sub-module tc_rr_pick: combinational round-robin selector. Inputs are req[N_WAY] and cur index. Outputs are next index and the flag any_other. It is instantiated once.
- Top holds the FSM, the counter and the lamp decode loop.

## Test plan
- Reset: hold R=0 for 2 cycles, then release with T=0. Required: L approach 0 = 001 and all others = 100. PHASE=0 stays constant for 20 cycles.
- Basic handover (N_WAY=4, defaults): T=4'b0100 from reset. Required: GREEN for 4 cycles, YELLOW on approach 0 for 5 cycles, ALLRED for 1 cycle, then approach 2 green with ACTIVE=2.
- Round-robin: ACTIVE=1, T=4'b1101, T[1]=0. Required: the grant order is 2, 3, 0 on successive handovers, with T bits held until served.
- Minimum green: a request on another approach arrives while cnt=0 and T[active]=0. Required: yellow does not begin before 4 green cycles have elapsed.
- Emergency: assert EMG for 10 cycles mid-GREEN. Required: immediate YELLOW for 5 cycles, ALLRED, then HOLD with all lamps 100 until EMG drops. Then 1 ALLRED cycle, then the next requester is green.
- Reset mid-YELLOW: R=0 at yellow cycle 3. Required: the next cycle shows approach 0 green and PHASE=0.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared lamp encodings, FSM state codes and helpers for the
// N-way traffic-light controller.
package tc_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tc_rr_pick.sv
// Round-robin selector: first waiting approach after cur,
// falling back to cur+1 when nobody else is waiting.
module tc_rr_pick #(
    parameter int N_WAY = 4,
    parameter int AW    = $clog2(N_WAY)
) (
    input  logic [N_WAY-1:0] req,
    input  logic [AW-1:0]    cur,
    output logic [AW-1:0]    nxt,
    output logic             any_other
);

    logic [AW-1:0] j;

    // Scan farthest-first so the nearest waiting index wins.
    always_comb begin
        j         = '0;
        nxt       = AW'((int'(cur) + 1) % N_WAY);
        any_other = 1'b0;
        for (int k = N_WAY - 1; k >= 1; k--) begin
            j = AW'((int'(cur) + k) % N_WAY);
            if (req[j]) begin
                nxt       = j;
                any_other = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tc_moore_nway.sv
// Moore traffic-light controller for an N-way junction with
// minimum green, timed yellow, all-red clearance and emergency hold.
module tc_moore_nway
    import tc_pkg::*;
#(
    parameter int N_WAY     = 4,
    parameter int GREEN_MIN = 4,
    parameter int YELLOW_T  = 5
) (
    input  logic                 CLK,
    input  logic                 R,
    input  logic [N_WAY-1:0]     T,
    input  logic                 EMG,
    output logic [3*N_WAY-1:0]   L,
    output logic [$clog2(N_WAY)-1:0] ACTIVE,
    output logic [1:0]           PHASE
);

    localparam int AW   = $clog2(N_WAY);
    localparam int MAXD = imax(GREEN_MIN, YELLOW_T);
    localparam int CW   = $clog2(MAXD + 1);

    localparam logic [CW-1:0] G_LAST = CW'(GREEN_MIN - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_T - 1);
    localparam logic [CW-1:0] C_SAT  = CW'(MAXD);

    state_t        state;
    logic [AW-1:0] active;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [AW-1:0] nxt;
    logic          any_other;
    logic          go_yel;

    tc_rr_pick #(
        .N_WAY (N_WAY),
        .AW    (AW)
    ) u_pick (
        .req       (T),
        .cur       (active),
        .nxt       (nxt),
        .any_other (any_other)
    );

    assign cnt_inc = (cnt == C_SAT) ? cnt : cnt + CW'(1);

    // Emergency overrides the minimum green time.
    assign go_yel = EMG
                 || ((cnt >= G_LAST) && !T[active] && any_other);

    always_ff @(posedge CLK) begin
        if (!R) begin
            state  <= GREEN;
            active <= '0;
            cnt    <= '0;
        end else begin
            unique case (state)
                GREEN: begin
                    if (go_yel) begin
                        state <= YELLOW;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                YELLOW: begin
                    if (cnt >= Y_LAST) begin
                        state <= ALLRED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ALLRED: begin
                    cnt <= '0;
                    if (EMG) begin
                        state <= HOLD;
                    end else begin
                        state  <= GREEN;
                        active <= nxt;
                    end
                end
                HOLD: begin
                    if (!EMG) begin
                        state <= ALLRED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= GREEN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        L = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (active == AW'(i) && state == GREEN)
                L[3*i +: 3] = LAMP_GRN;
            else if (active == AW'(i) && state == YELLOW)
                L[3*i +: 3] = LAMP_YEL;
            else
                L[3*i +: 3] = LAMP_RED;
        end
    end

    assign ACTIVE = active;
    assign PHASE  = state;

endmodule

// File: tb/tb_tc_moore_nway.sv
// Directed vector bench for tc_moore_nway at default parameters.
module tb_tc_moore_nway;

    localparam logic [1:0] P_G = 2'd0;
    localparam logic [1:0] P_Y = 2'd1;
    localparam logic [1:0] P_A = 2'd2;
    localparam logic [1:0] P_H = 2'd3;

    typedef struct {
        logic       r;
        logic [3:0] t;
        logic       emg;
        logic [1:0] ph;
        logic [1:0] act;
    } vec_t;

    logic        clk = 1'b0;
    logic        r   = 1'b0;
    logic [3:0]  t   = '0;
    logic        emg = 1'b0;
    logic [11:0] l;
    logic [1:0]  active;
    logic [1:0]  phase;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    tc_moore_nway #(
        .N_WAY     (4),
        .GREEN_MIN (4),
        .YELLOW_T  (5)
    ) dut (
        .CLK    (clk),
        .R      (r),
        .T      (t),
        .EMG    (emg),
        .L      (l),
        .ACTIVE (active),
        .PHASE  (phase)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_l(input logic [1:0] ph,
                                          input logic [1:0] a);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            if (ph == P_G && a == 2'(i))      v[3*i +: 3] = 3'b001;
            else if (ph == P_Y && a == 2'(i)) v[3*i +: 3] = 3'b010;
            else                              v[3*i +: 3] = 3'b100;
        end
        return v;
    endfunction

    task automatic add(input logic r_i, input logic [3:0] t_i,
                       input logic e_i, input logic [1:0] ph_i,
                       input logic [1:0] a_i, input int n);
        vec_t v;
        v.r = r_i; v.t = t_i; v.emg = e_i; v.ph = ph_i; v.act = a_i;
        repeat (n) vq.push_back(v);
    endtask

    task automatic rst(input logic [3:0] t_i);
        add(1'b0, t_i, 1'b0, P_G, 2'd0, 1);
    endtask

    task automatic hand(input logic [3:0] t_i, input logic [1:0] a,
                        input logic [1:0] nx);
        add(1'b1, t_i, 1'b0, P_G, a, 3);
        add(1'b1, t_i, 1'b0, P_Y, a, 5);
        add(1'b1, t_i, 1'b0, P_A, a, 1);
        add(1'b1, t_i, 1'b0, P_G, nx, 1);
    endtask

    task automatic step(input logic r_i, input logic [3:0] t_i,
                        input logic e_i);
        @(negedge clk);
        r = r_i; t = t_i; emg = e_i;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [1:0] ph,
                         input logic [1:0] a);
        n_vec++;
        if (phase !== ph || active !== a || l !== exp_l(ph, a)) begin
            n_bad++;
            $display("FAIL %s: got phase=%0d active=%0d L=%b, want phase=%0d active=%0d L=%b",
                     nm, phase, active, l, ph, a, exp_l(ph, a));
        end
    endtask

    initial begin
        int n;
        // reset and idle
        add(1'b0, 4'b0000, 1'b0, P_G, 2'd0, 2);
        add(1'b1, 4'b0000, 1'b0, P_G, 2'd0, 20);
        // basic handover to approach 2
        rst(4'b0100);
        hand(4'b0100, 2'd0, 2'd2);
        // round robin 1 -> 2 -> 3 -> 0
        rst(4'b0010);
        hand(4'b0010, 2'd0, 2'd1);
        hand(4'b1101, 2'd1, 2'd2);
        hand(4'b1001, 2'd2, 2'd3);
        hand(4'b0001, 2'd3, 2'd0);
        // saturated counter: late request leaves at once
        rst(4'b0000);
        add(1'b1, 4'b0000, 1'b0, P_G, 2'd0, 10);
        add(1'b1, 4'b0010, 1'b0, P_Y, 2'd0, 1);
        // active approach still waiting keeps green
        rst(4'b0000);
        add(1'b1, 4'b0011, 1'b0, P_G, 2'd0, 8);
        add(1'b1, 4'b0010, 1'b0, P_Y, 2'd0, 1);
        // emergency hold for 10 cycles
        rst(4'b0000);
        add(1'b1, 4'b0000, 1'b0, P_G, 2'd0, 2);
        add(1'b1, 4'b0100, 1'b1, P_Y, 2'd0, 5);
        add(1'b1, 4'b0100, 1'b1, P_A, 2'd0, 1);
        add(1'b1, 4'b0100, 1'b1, P_H, 2'd0, 4);
        add(1'b1, 4'b0100, 1'b0, P_A, 2'd0, 1);
        add(1'b1, 4'b0100, 1'b0, P_G, 2'd2, 1);
        // one-cycle EMG pulse, nobody waiting: fallback to 1
        rst(4'b0000);
        add(1'b1, 4'b0000, 1'b1, P_Y, 2'd0, 1);
        add(1'b1, 4'b0000, 1'b0, P_Y, 2'd0, 4);
        add(1'b1, 4'b0000, 1'b0, P_A, 2'd0, 1);
        add(1'b1, 4'b0000, 1'b0, P_G, 2'd1, 1);
        // reset during HOLD
        rst(4'b0000);
        add(1'b1, 4'b0000, 1'b1, P_Y, 2'd0, 5);
        add(1'b1, 4'b0000, 1'b1, P_A, 2'd0, 1);
        add(1'b1, 4'b0000, 1'b1, P_H, 2'd0, 1);
        add(1'b0, 4'b0000, 1'b1, P_G, 2'd0, 1);
        add(1'b1, 4'b0000, 1'b1, P_Y, 2'd0, 1);
        // reset at yellow cycle 3
        rst(4'b0100);
        add(1'b1, 4'b0100, 1'b0, P_G, 2'd0, 3);
        add(1'b1, 4'b0100, 1'b0, P_Y, 2'd0, 3);
        add(1'b0, 4'b0100, 1'b0, P_G, 2'd0, 1);
        add(1'b1, 4'b0000, 1'b0, P_G, 2'd0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].r, vq[i].t, vq[i].emg);
            check($sformatf("vec%0d", i), vq[i].ph, vq[i].act);
        end

        // hand-timed phase lengths with bounded waits
        step(1'b0, 4'b0010, 1'b0);
        check("hw_reset", P_G, 2'd0);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 4'b0010, 1'b0);
            if (phase == P_Y) break;
            n++;
        end
        n_vec++;
        if (n != 4) begin
            n_bad++;
            $display("FAIL hw_green_len: got %0d cycles, want 4", n);
        end
        n = 1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 4'b0010, 1'b0);
            if (phase != P_Y) break;
            n++;
        end
        n_vec++;
        if (n != 5) begin
            n_bad++;
            $display("FAIL hw_yellow_len: got %0d cycles, want 5", n);
        end
        check("hw_allred", P_A, 2'd0);
        step(1'b1, 4'b0010, 1'b0);
        check("hw_grant", P_G, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
